// File: rtl/safe_pkg.sv
// Shared types for the safe keypad front end and the safe controller:
// data_in key codes, per-key debounce FSM states and the door-sensor bit index.
package safe_pkg;

   typedef enum logic [2:0] {
      KEY_0       = 3'd0,
      KEY_1       = 3'd1,
      KEY_2       = 3'd2,
      KEY_3       = 3'd3,
      KEY_OK      = 3'd4,
      KEY_CLEAR   = 3'd5,
      DOOR_SEALED = 3'd6
   } data_in_t;

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} key_fsm_t;

   localparam int KEY_DOOR_IDX = 6;

endpackage

// File: rtl/safe_key_debounce.sv
// One contact: 2-flop synchroniser, press/release debounce FSM and, when
// SAFE_KEYPAD_REPEAT_EN is defined, the auto-repeat timer.
module safe_key_debounce
   import safe_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 500,
   parameter int REPEAT_PERIOD   = 100
`ifdef SAFE_KEYPAD_REPEAT_EN
   ,
   parameter bit REPEAT_OK       = 1'b1
`endif
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic req_o,
   output logic held_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("safe_key_debounce: timing parameters must be >= 1");
   end

   logic          sync1, sync2;
   key_fsm_t      state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          press_req;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw_i;
         sync2 <= sync1;
      end
   end

   // Reset lands in REL_DB so a contact closed through reset must open first.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= REL_DB;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      press_req = 1'b0;
      unique case (state)
         IDLE: begin
            if (sync2) begin
               state_nx = PRESS_DB;
               cnt_nx   = '0;
            end
         end
         PRESS_DB: begin
            if (!sync2) begin
               state_nx = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nx  = HELD;
               cnt_nx    = CNT_MAX;
               press_req = 1'b1;
            end else begin
               cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
            end
         end
         HELD: begin
            if (!sync2) begin
               state_nx = REL_DB;
               cnt_nx   = '0;
            end
         end
         REL_DB: begin
            if (sync2) begin
               state_nx = HELD;
            end else if (cnt == CNT_LAST) begin
               state_nx = IDLE;
               cnt_nx   = CNT_MAX;
            end else begin
               cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
            end
         end
         default: state_nx = REL_DB;
      endcase
   end

   assign held_o = (state == HELD);

`ifdef SAFE_KEYPAD_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rcnt, rcnt_nx;
   logic          armed, armed_nx, first, first_nx, rep_req;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rcnt  <= '0;
         armed <= 1'b0;
         first <= 1'b0;
      end else begin
         rcnt  <= rcnt_nx;
         armed <= armed_nx;
         first <= first_nx;
      end
   end

   // Only a genuine press arms repeat; a contact stuck through reset never does.
   always_comb begin
      rcnt_nx  = rcnt;
      armed_nx = armed;
      first_nx = first;
      rep_req  = 1'b0;
      if (press_req) begin
         armed_nx = REPEAT_OK;
         first_nx = 1'b1;
         rcnt_nx  = RW'(1);
      end else if (state == HELD && sync2 && armed) begin
         if (rcnt == (first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD))) begin
            rep_req  = 1'b1;
            first_nx = 1'b0;
            rcnt_nx  = RW'(1);
         end else if (rcnt != RW'(RMAX)) begin
            rcnt_nx = rcnt + RW'(1);
         end
      end
      if (state_nx == IDLE) armed_nx = 1'b0;
   end

   assign req_o = press_req | rep_req;
`else
   assign req_o = press_req;
`endif

endmodule

// File: rtl/safe_keypad_frontend.sv
// Keypad/door-sensor front end: per-contact debounce, single-press arbitration
// with ghost rejection, registered event pulses. Auto-repeat: SAFE_KEYPAD_REPEAT_EN.
module safe_keypad_frontend
   import safe_pkg::*;
#(
   parameter int NUM_KEYS        = 7,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 500,
   parameter int REPEAT_PERIOD   = 100
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_KEYS-1:0] raw_keys_i,
   output logic                key_0_o,
   output logic                key_1_o,
   output logic                key_2_o,
   output logic                key_3_o,
   output logic                key_ok_o,
   output logic                key_clear_o,
   output logic                door_sealed_o,
   output logic [2:0]          key_code_o,
   output logic                key_valid_o,
   output logic                multi_key_o
);

   if (NUM_KEYS != 7) begin : g_bad_cfg
      $error("safe_keypad_frontend: NUM_KEYS must match the data_in code set (7)");
   end

   logic [NUM_KEYS-1:0] req, held;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      safe_key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`ifdef SAFE_KEYPAD_REPEAT_EN
         ,
         .REPEAT_OK       (i != KEY_DOOR_IDX)
`endif
      ) u_key (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .raw_i  (raw_keys_i[i]),
         .req_o  (req[i]),
         .held_o (held[i])
      );
   end

   logic     fire, drop;
   data_in_t ev_code;

   // A lone request wins only if no other key is still held down.
   always_comb begin
      fire    = 1'b0;
      drop    = 1'b0;
      ev_code = KEY_0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (req[i]) ev_code = data_in_t'(3'(i));
      end
      if (|req) begin
         if ($onehot(req) && !(|(held & ~req))) fire = 1'b1;
         else                                   drop = 1'b1;
      end
   end

   logic [NUM_KEYS-1:0] pulse_q;
   data_in_t            code_q;
   logic                valid_q, multi_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pulse_q <= '0;
         code_q  <= KEY_0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         pulse_q <= fire ? req : '0;
         valid_q <= fire;
         multi_q <= drop;
         if (fire) code_q <= ev_code;
      end
   end

   assign key_0_o       = pulse_q[0];
   assign key_1_o       = pulse_q[1];
   assign key_2_o       = pulse_q[2];
   assign key_3_o       = pulse_q[3];
   assign key_ok_o      = pulse_q[4];
   assign key_clear_o   = pulse_q[5];
   assign door_sealed_o = pulse_q[KEY_DOOR_IDX];
   assign key_code_o    = code_q;
   assign key_valid_o   = valid_q;
   assign multi_key_o   = multi_q;

endmodule

// File: tb/tb_safe_keypad_frontend.sv
// Scoreboard bench for safe_keypad_frontend: a run-length contact model predicts
// each event and its edge; a negedge monitor pops and compares.
module tb_safe_keypad_frontend;

   localparam int NK = 7;
   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] raw = '0;
   logic k0, k1, k2, k3, kok, kclr, kdoor, valid, multi;
   logic [2:0] code;

   safe_keypad_frontend #(
      .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk_i(clk), .rst_i(rst), .raw_keys_i(raw),
      .key_0_o(k0), .key_1_o(k1), .key_2_o(k2), .key_3_o(k3),
      .key_ok_o(kok), .key_clear_o(kclr), .door_sealed_o(kdoor),
      .key_code_o(code), .key_valid_o(valid), .multi_key_o(multi)
   );

   always #5 clk = ~clk;

   typedef struct { int due; bit is_multi; int code; } exp_t;
   exp_t q[$];
   int edge_n = 0;
   int total = 0;
   int passed = 0;

   task automatic chk(input string name, input bit ok, input int act, input int exp);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
   endtask

   // Reference: each contact has an accepted level and a run of opposite samples.
   // A level flips after D+1 consecutive opposite synchronised samples; reset
   // accepts "closed" with one opening sample already counted.
   bit m_s1[NK], m_s2[NK], m_lvl[NK];
   int m_run[NK];

   always @(posedge clk) begin : model
      int nreq, rk;
      bit other_held;
      bit req[NK];
      bit held[NK];
      bit smp;
      edge_n++;
      if (rst) begin
         for (int k = 0; k < NK; k++) begin
            m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 1; m_run[k] = 1;
         end
      end else begin
         nreq = 0; rk = 0; other_held = 0;
         for (int k = 0; k < NK; k++) begin
            held[k] = m_lvl[k] && (m_run[k] == 0);
            smp = m_s2[k];
            req[k] = 0;
            if (smp != m_lvl[k]) begin
               m_run[k]++;
               if (m_run[k] == D + 1) begin
                  req[k] = !m_lvl[k];
                  m_lvl[k] = smp;
                  m_run[k] = 0;
               end
            end else begin
               m_run[k] = 0;
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = raw[k];
         end
         for (int k = 0; k < NK; k++) if (req[k]) begin nreq++; rk = k; end
         for (int k = 0; k < NK; k++) if (held[k] && !req[k]) other_held = 1;
         if (nreq == 1 && !other_held) q.push_back('{edge_n, 1'b0, rk});
         else if (nreq > 0)            q.push_back('{edge_n, 1'b1, 0});
      end
   end

   int exp_code = 0;

   always @(negedge clk) begin : monitor
      logic [NK-1:0] pv;
      exp_t e;
      if (edge_n > 0) begin
         pv = {kdoor, kclr, kok, k3, k2, k1, k0};
         while (q.size() > 0 && q[0].due < edge_n) begin
            chk("event_missing", 1'b0, edge_n, q[0].due);
            void'(q.pop_front());
         end
         if (rst) begin
            chk("reset_outputs", {pv, valid, multi, code} == '0,
                int'({pv, valid, multi, code}), 0);
            exp_code = 0;
         end else if (pv != '0 || valid || multi) begin
            if (q.size() == 0 || q[0].due != edge_n) begin
               chk("unexpected_event", 1'b0, int'({multi, valid, pv}), 0);
            end else begin
               e = q.pop_front();
               if (e.is_multi) begin
                  chk("multi_key", multi == 1'b1, int'(multi), 1);
                  chk("ghost_no_pulse", pv == '0 && !valid, int'({valid, pv}), 0);
                  chk("ghost_code_hold", int'(code) == exp_code, int'(code), exp_code);
               end else begin
                  chk("key_pulse", pv == NK'(1 << e.code), int'(pv), 1 << e.code);
                  chk("key_valid", valid == 1'b1, int'(valid), 1);
                  chk("key_code", int'(code) == e.code, int'(code), e.code);
                  chk("no_multi", multi == 1'b0, int'(multi), 0);
                  exp_code = e.code;
               end
            end
         end else begin
            chk("code_hold", int'(code) == exp_code, int'(code), exp_code);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin : stim
      int e0, k1r, k2r, off, hold, bnc;
      bit two;
      step(3);
      rst = 1'b0;
      step(10);

      // 1: bounced press of digit 2, exact latency from first stable sample
      raw[2] = 1; step(1); raw[2] = 0; step(1); raw[2] = 1; step(1); raw[2] = 0; step(1);
      raw[2] = 1;
      e0 = edge_n + 1;
      while (edge_n < e0 + 5) step(1);
      chk("t1_early", k2 == 1'b0, int'(k2), 0);
      step(1);
      chk("t1_latency", k2 && valid && code == 3'd2, int'({k2, valid, code}), 'b11010);
      step(1);
      chk("t1_single", !k2 && !valid, int'({k2, valid}), 0);
      step(5);
      raw[2] = 0; step(15);

      // 2: OK held through reset is suppressed, then a fresh press counts
      raw[4] = 1; rst = 1'b1; step(3);
      rst = 1'b0; step(18);
      raw[4] = 0; step(10);
      raw[4] = 1; step(12);
      raw[4] = 0; step(12);

      // 3: second key while one is held -> ghost; later alone -> accepted
      raw[1] = 1; step(10);
      raw[3] = 1; step(10);
      raw[1] = 0; raw[3] = 0; step(12);
      raw[3] = 1; step(10);
      raw[3] = 0; step(12);

      // 4: two simultaneous presses
      raw[0] = 1; raw[5] = 1; step(10);
      raw[0] = 0; raw[5] = 0; step(12);

      // 5: reset during door-sensor debounce, short reopen, then proper reopen
      raw[6] = 1; step(4);
      rst = 1'b1; step(1);
      rst = 1'b0; step(10);
      raw[6] = 0; step(3);
      raw[6] = 1; step(10);
      raw[6] = 0; step(8);
      raw[6] = 1; step(10);
      raw[6] = 0; step(12);

      // random episodes: bounce, single or overlapping presses, bouncy release
      for (int ep = 0; ep < 40; ep++) begin
         k1r  = $urandom_range(0, NK - 1);
         k2r  = $urandom_range(0, NK - 1);
         two  = ($urandom_range(0, 3) == 0);
         off  = $urandom_range(0, 3);
         hold = $urandom_range(3, 11);
         bnc  = $urandom_range(0, 4);
         repeat (bnc) begin raw[k1r] = 1'($urandom_range(0, 1)); step(1); end
         raw[k1r] = 1;
         for (int t = 0; t <= hold + off; t++) begin
            if (two && t == off) raw[k2r] = 1;
            step(1);
         end
         repeat ($urandom_range(0, 3)) begin
            raw[k1r] = 1'($urandom_range(0, 1));
            if (two) raw[k2r] = 1'($urandom_range(0, 1));
            step(1);
         end
         raw = '0;
         step(14);
      end

`ifdef SAFE_KEYPAD_REPEAT_EN
      // 6: auto-repeat on digit 3, none on the door sensor
      raw[3] = 1;
      e0 = edge_n + 1 + 6;
      while (edge_n < e0) step(1);
      q.push_back('{e0 + RD, 1'b0, 3});
      q.push_back('{e0 + RD + RP, 1'b0, 3});
      q.push_back('{e0 + RD + 2 * RP, 1'b0, 3});
      while (edge_n < e0 + 38) step(1);
      raw[3] = 0; step(14);
      raw[6] = 1; step(60);
      raw[6] = 0; step(14);
`endif

      step(5);
      chk("queue_drained", q.size() == 0, q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
